// File: rtl/mips_cpu_pkg.sv
// Shared types and decode constants for the multicycle MIPS core.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    HALT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC1  = 3'd3,
    EXEC2  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    LONG    = 2'd0,
    SHORT   = 2'd1,
    ILLEGAL = 2'd2
  } iclass_t;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;
  localparam logic [5:0] FN_ADD_LO = 6'h20;
  localparam logic [5:0] FN_ADD_HI = 6'h26;

endpackage

// File: rtl/mips_cpu_iclass.sv
// Instruction class decode: how many execute cycles an instruction needs.
module mips_cpu_iclass
  import mips_cpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] fncode,
  output iclass_t    iclass
);

  // Classify by opcode, refining R-type by function code
  always_comb begin
    iclass = ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        if (fncode >= FN_ADD_LO && fncode <= FN_ADD_HI)
          iclass = LONG;
        else if (fncode == FN_JR || fncode == FN_JALR)
          iclass = SHORT;
      end
      OP_LW, OP_SW: iclass = LONG;
      OP_BEQ:       iclass = SHORT;
      default:      iclass = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mips_cpu_sequencer.sv
// Multicycle state sequencer: FSM, instruction register, load data register
// and retired-instruction counter.
//
// state  | meaning
// HALT   | stopped by a halting jump or an illegal instruction; reset only exit
// FETCH  | instruction read on the bus; IR loads when the bus is ready
// DECODE | class decode; illegal opcodes halt here
// EXEC1  | first execute cycle; lw data captured into MDR
// EXEC2  | second execute cycle for LONG instructions
module mips_cpu_sequencer
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] jump_target,
  output logic [2:0]  state,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  fncode,
  output logic [31:0] mdr,
  output logic        stall,
  output logic        active,
  output logic        error,
  output logic [31:0] retired
);

  state_t  st;
  iclass_t iclass;
  logic    is_jump;
  logic    halt_jump;

  assign state  = st;
  assign opcode = instr[31:26];
  assign fncode = instr[5:0];
  assign stall  = waitrequest & (memread | memwrite);

  assign is_jump   = (opcode == OP_RTYPE) && (fncode == FN_JR || fncode == FN_JALR);
  assign halt_jump = is_jump && (jump_target == HALT_ADDR);

  mips_cpu_iclass u_iclass (
    .opcode (opcode),
    .fncode (fncode),
    .iclass (iclass)
  );

  // Sequencer FSM; every state holds while the current bus access stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= FETCH;
      instr   <= 32'h0;
      mdr     <= 32'h0;
      active  <= 1'b1;
      error   <= 1'b0;
      retired <= 32'h0;
    end else if (!stall) begin
      case (st)
        FETCH: begin
          instr <= readdata;
          st    <= DECODE;
        end
        DECODE: begin
          if (iclass == ILLEGAL) begin
            st     <= HALT;
            active <= 1'b0;
            error  <= 1'b1;
          end else begin
            st <= EXEC1;
          end
        end
        EXEC1: begin
          if (opcode == OP_LW)
            mdr <= readdata;
          if (iclass == LONG) begin
            st <= EXEC2;
          end else begin
            retired <= retired + 32'd1;
            if (halt_jump) begin
              st     <= HALT;
              active <= 1'b0;
            end else begin
              st <= FETCH;
            end
          end
        end
        EXEC2: begin
          retired <= retired + 32'd1;
          st      <= FETCH;
        end
        default: begin
          st     <= HALT;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule
